// File: rtl/aoi211_arc_sequencer.sv
// rtl/aoi211_arc_sequencer.sv - walks the 8 sensitized AOI211 timing arcs and checks ZN per phase
module aoi211_arc_sequencer #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 5
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             zn,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_c1,
  output logic             drv_c2,
  output logic [2:0]       arc_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_mask,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(SETTLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RISE  = 3'd2;
  localparam logic [2:0] S_FALL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [2:0]       arc_q, arc_d;
  logic [3:0]       drv_q, drv_d;
  logic [7:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             zn_s1_q, zn_s2_q;
  logic             exp_zn;

  // Drive vector {A,B,C1,C2}: side inputs of the arc, plus the switching pin when sw=1.
  function automatic logic [3:0] arc_drive(input logic [2:0] arc, input logic sw);
    logic [3:0] side;
    logic [3:0] pin;
    case (arc)
      3'd0: begin side = 4'b0000; pin = 4'b1000; end
      3'd1: begin side = 4'b0001; pin = 4'b1000; end
      3'd2: begin side = 4'b0010; pin = 4'b1000; end
      3'd3: begin side = 4'b0000; pin = 4'b0100; end
      3'd4: begin side = 4'b0001; pin = 4'b0100; end
      3'd5: begin side = 4'b0010; pin = 4'b0100; end
      3'd6: begin side = 4'b0001; pin = 4'b0010; end
      default: begin side = 4'b0010; pin = 4'b0001; end
    endcase
    return sw ? (side | pin) : side;
  endfunction

  assign exp_zn = (state_q != S_RISE);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    arc_d   = arc_q;
    drv_d   = drv_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          tmr_d   = TLOAD;
          arc_d   = 3'd0;
          drv_d   = arc_drive(3'd0, 1'b0);
          mask_d  = 8'h00;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_SETUP, S_RISE, S_FALL: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          if (zn_s2_q != exp_zn) begin
            mask_d[arc_q] = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end
          tmr_d = TLOAD;
          if (state_q == S_SETUP) begin
            state_d = S_RISE;
            drv_d   = arc_drive(arc_q, 1'b1);
          end else if (state_q == S_RISE) begin
            state_d = S_FALL;
            drv_d   = arc_drive(arc_q, 1'b0);
          end else if (arc_q != 3'd7) begin
            state_d = S_SETUP;
            arc_d   = arc_q + 3'd1;
            drv_d   = arc_drive(arc_q + 3'd1, 1'b0);
          end else begin
            // pass sees the mask including this final compare
            state_d = S_DONE;
            drv_d   = 4'b0000;
            pass_d  = (mask_d == 8'h00);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      arc_q   <= 3'd0;
      drv_q   <= 4'b0000;
      mask_q  <= 8'h00;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      zn_s1_q <= 1'b0;
      zn_s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      arc_q   <= arc_d;
      drv_q   <= drv_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      zn_s1_q <= zn;
      zn_s2_q <= zn_s1_q;
    end
  end

  assign {drv_a, drv_b, drv_c1, drv_c2} = drv_q;
  assign arc_idx  = arc_q;
  assign busy     = (state_q == S_SETUP) || (state_q == S_RISE) || (state_q == S_FALL);
  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign err_mask = mask_q;
  assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_aoi211_arc_sequencer.sv
// tb/tb_aoi211_arc_sequencer.sv - directed and random-truth-table runs against an arc-table reference model
module tb_aoi211_arc_sequencer;

  logic       CK = 1'b0;
  logic       RN;
  logic       start;
  logic       zn;
  logic       drv_a, drv_b, drv_c1, drv_c2;
  logic [2:0] arc_idx;
  logic       busy, done, pass;
  logic [7:0] err_mask;
  logic [4:0] err_cnt;

  // Cell under characterization, modelled as a 16-entry truth table indexed by {A,B,C1,C2}
  logic [15:0] tt;
  assign zn = tt[{drv_a, drv_b, drv_c1, drv_c2}];

  int checks = 0;
  int errors = 0;

  aoi211_arc_sequencer #(.SETTLE(4), .CNT_W(5)) dut (
    .CK(CK), .RN(RN), .start(start), .zn(zn),
    .drv_a(drv_a), .drv_b(drv_b), .drv_c1(drv_c1), .drv_c2(drv_c2),
    .arc_idx(arc_idx), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_cnt(err_cnt)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arc table: side inputs and switching pin, as {A,B,C1,C2}
  function automatic logic [3:0] ref_drive(input int arc, input bit sw);
    logic [3:0] side [8];
    logic [3:0] pin  [8];
    side = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    pin  = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0001};
    return sw ? (side[arc] | pin[arc]) : side[arc];
  endfunction

  task automatic ref_model(input logic [15:0] t, output logic [7:0] m, output int c);
    logic [3:0] v;
    m = 8'h00;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 3; p++) begin
        v = ref_drive(i, p == 1);
        if (t[v] !== (p != 1)) begin
          m[i] = 1'b1;
          c++;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".drv"},  32'({drv_a, drv_b, drv_c1, drv_c2}), 32'(0));
    chk({tag, ".arc"},  32'(arc_idx), 32'(0));
    chk({tag, ".flags"}, 32'({busy, done, pass}), 32'(0));
    chk({tag, ".mask"}, 32'(err_mask), 32'(0));
    chk({tag, ".cnt"},  32'(err_cnt), 32'(0));
  endtask

  // One run: start pulse, 96 busy cycles checked against the arc table, DONE, then hold in IDLE.
  task automatic run(input string name, input logic [15:0] t, input bit repulse, input int rst_at);
    logic [7:0] em;
    int         ec;
    int         ph;
    tt = t;
    ref_model(t, em, ec);
    chk({name, ".idle_busy"}, 32'(busy), 32'(0));
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    for (int k = 0; k < 96; k++) begin
      if (k == rst_at) begin
        RN = 1'b0;
        #1;
        chk_all_zero({name, ".rst_async"});
        @(negedge CK);
        chk_all_zero({name, ".rst_hold"});
        RN = 1'b1;
        @(negedge CK);
        chk_all_zero({name, ".rst_idle"});
        return;
      end
      ph = k / 4;
      chk({name, ".busy"}, 32'(busy), 32'(1));
      chk({name, ".done_lo"}, 32'(done), 32'(0));
      chk({name, ".arc"}, 32'(arc_idx), 32'(ph / 3));
      chk({name, ".drv"}, 32'({drv_a, drv_b, drv_c1, drv_c2}), 32'(ref_drive(ph / 3, (ph % 3) == 1)));
      if (k == 0) chk({name, ".pass_clr"}, 32'(pass), 32'(0));
      start = repulse && (k == 10 || k == 95);
      @(negedge CK);
    end
    start = 1'b0;
    chk({name, ".done"}, 32'(done), 32'(1));
    chk({name, ".done_busy"}, 32'(busy), 32'(0));
    chk({name, ".done_drv"}, 32'({drv_a, drv_b, drv_c1, drv_c2}), 32'(0));
    chk({name, ".pass"}, 32'(pass), 32'(em == 8'h00));
    chk({name, ".mask"}, 32'(err_mask), 32'(em));
    chk({name, ".cnt"}, 32'(err_cnt), 32'(ec));
    @(negedge CK);
    chk({name, ".post_done"}, 32'({done, busy}), 32'(0));
    chk({name, ".hold_pass"}, 32'(pass), 32'(em == 8'h00));
    chk({name, ".hold_mask"}, 32'(err_mask), 32'(em));
    chk({name, ".hold_cnt"}, 32'(err_cnt), 32'(ec));
  endtask

  initial begin
    logic [15:0] golden;
    logic [15:0] faulty;
    logic [3:0]  v;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      golden[i] = ~((v[1] & v[0]) | v[3] | v[2]);
      faulty[i] = ~(v[1] | v[3] | v[2]);
    end
    RN    = 1'b0;
    start = 1'b0;
    tt    = golden;
    repeat (2) @(negedge CK);
    chk_all_zero("reset");
    RN = 1'b1;
    @(negedge CK);
    chk_all_zero("idle");

    run("golden", golden, 1'b0, -1);
    chk("golden.lit", 32'({pass, err_mask, err_cnt}), 32'({1'b1, 8'h00, 5'd0}));
    run("stuck0", 16'h0000, 1'b0, -1);
    chk("stuck0.lit", 32'({pass, err_mask, err_cnt}), 32'({1'b0, 8'hFF, 5'd16}));
    run("stuck1", 16'hFFFF, 1'b0, -1);
    chk("stuck1.lit", 32'({pass, err_mask, err_cnt}), 32'({1'b0, 8'hFF, 5'd8}));
    run("noc2", faulty, 1'b0, -1);
    chk("noc2.lit", 32'({pass, err_mask, err_cnt}), 32'({1'b0, 8'hA4, 5'd6}));
    run("midreset", faulty, 1'b0, 40);
    run("rerun", golden, 1'b0, -1);
    chk("rerun.lit", 32'({pass, err_mask, err_cnt}), 32'({1'b1, 8'h00, 5'd0}));
    run("repulse", golden, 1'b1, -1);
    chk("repulse.lit", 32'({pass, err_mask, err_cnt}), 32'({1'b1, 8'h00, 5'd0}));

    for (int n = 0; n < 6; n++) begin
      r = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge CK);
      run("random", r[15:0], r[16], (r[20:17] == 4'd0) ? int'($urandom_range(1, 95)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
